fc2_ctrl: RTL and testbench

Sequencer for the second fully connected layer (120 -> 84, 12 parallel PEs, 7 output groups). It consumes the f6 buffer that the fc1 stage writes and drives four things: the f6 read address, the w6 weight ROM address, the PE accumulator clear, and the f7 write strobe and address. It starts on `fc2_start`, which is normally tied to the fc1 done pulse, and signals completion with a one-cycle `fc2_done`.

---
 rtl/fc2_pkg.sv | 26 ++
 rtl/fc2_ctrl_sig_delay.sv | 29 ++
 rtl/fc2_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fc2_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fc2_pkg.sv
// fc2_pkg: shared constants and state encoding for the fc2 sequencer.
// FC2_ADDR_PIPE_EN adds one address register stage and lengthens the delays.
package fc2_pkg;

  localparam int IN_NUM  = 120;
  localparam int OUT_GRP = 7;

`ifdef FC2_ADDR_PIPE_EN
  localparam int CLR_DLY = 6;
  localparam int WR_DLY  = 10;
`else
  localparam int CLR_DLY = 5;
  localparam int WR_DLY  = 9;
`endif

  localparam int IDX_W  = $clog2(IN_NUM);
  localparam int GRP_W  = $clog2(OUT_GRP);
  localparam int ADDR_W = $clog2(IN_NUM * OUT_GRP);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_DONE = 3'b100
  } state_t;

endpackage

// File: rtl/fc2_ctrl_sig_delay.sv
// sig_delay: reset-cleared shift register, DEPTH stages of WIDTH bits.
// Used to align raw controls with the datapath latency.
module sig_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr [DEPTH];

  // shift one stage per cycle, clear everything on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/fc2_ctrl.sv
// fc2_ctrl: 120->84 fully connected layer sequencer (7 groups of 12 PEs).
// Optional macro FC2_ADDR_PIPE_EN: extra address register stage.
module fc2_ctrl
  import fc2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       fc2_start,
  output logic       fc2_busy,
  output logic [6:0] f6_raddr,
  output logic [9:0] w6_raddr,
  output logic       fc2_clr,
  output logic       f7_wr_en,
  output logic [2:0] f7_waddr,
  output logic       fc2_done
);

  state_t state, state_nx;

  logic [IDX_W-1:0]  idx;
  logic [GRP_W-1:0]  grp;
  logic              idx_last;
  logic              grp_last;
  logic              busy;
  logic              raw_clr;
  logic              raw_wr;
  logic              raw_done;

  assign idx_last = (idx == IDX_W'(IN_NUM - 1));
  assign grp_last = (grp == GRP_W'(OUT_GRP - 1));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // next state and raw control strobes
  always_comb begin
    state_nx = ST_IDLE;
    busy     = 1'b0;
    raw_clr  = 1'b0;
    raw_wr   = 1'b0;
    raw_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fc2_start) state_nx = ST_RUN;
      end
      ST_RUN: begin
        busy     = 1'b1;
        raw_clr  = (idx == '0);
        raw_wr   = idx_last;
        state_nx = (idx_last && grp_last) ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        busy     = 1'b1;
        raw_done = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign fc2_busy = busy;

  // input index and group counters, parked at 0 outside RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      grp <= '0;
    end else if (state != ST_RUN) begin
      idx <= '0;
      grp <= '0;
    end else if (idx_last) begin
      idx <= '0;
      grp <= grp_last ? '0 : grp + 1'b1;
    end else begin
      idx <= idx + 1'b1;
    end
  end

  logic [ADDR_W-1:0] g_ext;
  logic [ADDR_W-1:0] prod;
  logic [ADDR_W-1:0] sum;

  // grp*119 from shifts; adding idx+grp then gives grp*120+idx
  assign g_ext = ADDR_W'(grp);
  assign prod  = (g_ext << 6) + (g_ext << 5) + (g_ext << 4)
               + (g_ext << 3) - g_ext;
  assign sum   = ADDR_W'(idx) + g_ext;

  logic [IDX_W-1:0]  s1_idx;
  logic [ADDR_W-1:0] s1_sum;
  logic [ADDR_W-1:0] s1_prod;
  logic [IDX_W-1:0]  s2_f6;
  logic [ADDR_W-1:0] s2_w6;

  // two-stage address pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_idx  <= '0;
      s1_sum  <= '0;
      s1_prod <= '0;
      s2_f6   <= '0;
      s2_w6   <= '0;
    end else begin
      s1_idx  <= idx;
      s1_sum  <= sum;
      s1_prod <= prod;
      s2_f6   <= s1_idx;
      s2_w6   <= s1_sum + s1_prod;
    end
  end

`ifdef FC2_ADDR_PIPE_EN
  logic [IDX_W-1:0]  s3_f6;
  logic [ADDR_W-1:0] s3_w6;

  // extra output register for the address bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_f6 <= '0;
      s3_w6 <= '0;
    end else begin
      s3_f6 <= s2_f6;
      s3_w6 <= s2_w6;
    end
  end

  assign f6_raddr = s3_f6;
  assign w6_raddr = s3_w6;
`else
  assign f6_raddr = s2_f6;
  assign w6_raddr = s2_w6;
`endif

  logic [GRP_W:0] wr_d;
  logic [GRP_W:0] wr_q;

  assign wr_d = {raw_wr, grp};

  sig_delay #(.DEPTH(CLR_DLY), .WIDTH(1)) u_clr_dly (
    .clk (clk),
    .rst (rst),
    .d   (raw_clr),
    .q   (fc2_clr)
  );

  sig_delay #(.DEPTH(WR_DLY), .WIDTH(GRP_W + 1)) u_wr_dly (
    .clk (clk),
    .rst (rst),
    .d   (wr_d),
    .q   (wr_q)
  );

  sig_delay #(.DEPTH(WR_DLY), .WIDTH(1)) u_done_dly (
    .clk (clk),
    .rst (rst),
    .d   (raw_done),
    .q   (fc2_done)
  );

  assign f7_wr_en = wr_q[GRP_W];
  assign f7_waddr = wr_q[GRP_W-1:0];

endmodule

// File: tb/tb_fc2_ctrl.sv
// tb_fc2_ctrl: vector table, directed sequences and random run
// checked against a pass-schedule reference model.
module tb_fc2_ctrl;

`ifdef FC2_ADDR_PIPE_EN
  localparam int SH = 1;
`else
  localparam int SH = 0;
`endif
  localparam int AL = 2 + SH;
  localparam int CL = 5 + SH;
  localparam int WL = 128 + SH;
  localparam int DL = 849 + SH;

  logic       clk = 1'b0;
  logic       rst;
  logic       fc2_start;
  logic       fc2_busy;
  logic [6:0] f6_raddr;
  logic [9:0] w6_raddr;
  logic       fc2_clr;
  logic       f7_wr_en;
  logic [2:0] f7_waddr;
  logic       fc2_done;

  fc2_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .fc2_start (fc2_start),
    .fc2_busy  (fc2_busy),
    .f6_raddr  (f6_raddr),
    .w6_raddr  (w6_raddr),
    .fc2_clr   (fc2_clr),
    .f7_wr_en  (f7_wr_en),
    .f7_waddr  (f7_waddr),
    .fc2_done  (fc2_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic [6:0] f6;
    logic [9:0] w6;
    logic       clr;
    logic       wr;
    logic [2:0] wa;
    logic       done;
  } out_t;

  typedef enum int {K_BUSY, K_F6, K_W6, K_CLR, K_WREN, K_WA, K_DONE} kind_e;

  typedef struct {
    int    d;
    bit    sh;
    kind_e k;
    int    v;
  } vec_t;

  vec_t tbl[$];
  int   passes[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   tbl_r = -1;
  int   last_acc = -1;
  int   wr_cnt, done_cnt, clr_cnt;

  function automatic void add(int d, bit sh, kind_e k, int v);
    vec_t t;
    t.d = d; t.sh = sh; t.k = k; t.v = v;
    tbl.push_back(t);
  endfunction

  // expected outputs at cycle c from the accepted pass start cycles
  function automatic out_t model(int c);
    out_t o;
    int   d, g;
    o = '0;
    foreach (passes[i]) begin
      d = c - passes[i];
      if (d >= 0 && d <= 840) o.busy = 1'b1;
      if (d >= AL && d <= AL + 839) begin
        o.w6 = 10'(d - AL);
        o.f6 = 7'((d - AL) % 120);
      end
      if (d >= CL && (d - CL) % 120 == 0 && (d - CL) / 120 < 7)
        o.clr = 1'b1;
      if (d >= WL && (d - WL) % 120 == 0) begin
        g = (d - WL) / 120;
        if (g < 7) begin
          o.wr = 1'b1;
          o.wa = 3'(g);
        end
      end
      if (d == DL) o.done = 1'b1;
    end
    return o;
  endfunction

  function automatic int pick(kind_e k);
    case (k)
      K_BUSY:  return int'(fc2_busy);
      K_F6:    return int'(f6_raddr);
      K_W6:    return int'(w6_raddr);
      K_CLR:   return int'(fc2_clr);
      K_WREN:  return int'(f7_wr_en);
      K_WA:    return int'(f7_waddr);
      default: return int'(fc2_done);
    endcase
  endfunction

  task automatic check_cycle();
    out_t e, a;
    int   at;
    e = model(cyc);
    a = '{busy: fc2_busy, f6: f6_raddr, w6: w6_raddr, clr: fc2_clr,
          wr: f7_wr_en, wa: (e.wr ? f7_waddr : 3'd0), done: fc2_done};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL model cyc=%0d actual busy=%b f6=%0d w6=%0d clr=%b wr=%b wa=%0d done=%b required busy=%b f6=%0d w6=%0d clr=%b wr=%b wa=%0d done=%b",
               cyc, a.busy, a.f6, a.w6, a.clr, a.wr, a.wa, a.done,
               e.busy, e.f6, e.w6, e.clr, e.wr, e.wa, e.done);
    end
    if (tbl_r >= 0) begin
      foreach (tbl[i]) begin
        at = tbl_r + tbl[i].d + (tbl[i].sh ? SH : 0);
        if (cyc == at) begin
          checks++;
          if (pick(tbl[i].k) != tbl[i].v) begin
            errors++;
            $display("FAIL vec%0d %s at R+%0d actual=%0d required=%0d",
                     i, tbl[i].k.name(), at - tbl_r,
                     pick(tbl[i].k), tbl[i].v);
          end
        end
      end
    end
    if (f7_wr_en === 1'b1) wr_cnt++;
    if (fc2_done === 1'b1) done_cnt++;
    if (fc2_clr === 1'b1) clr_cnt++;
  endtask

  task automatic step(input logic r, input logic s);
    out_t e;
    @(negedge clk);
    check_cycle();
    rst       = r;
    fc2_start = s;
    e = model(cyc);
    if (r) begin
      passes.delete();
    end else if (s && !e.busy) begin
      passes.push_back(cyc + 1);
      last_acc = cyc + 1;
    end
    while (passes.size() > 0 && passes[0] < cyc - 1000)
      void'(passes.pop_front());
    @(posedge clk);
    cyc++;
  endtask

  task automatic expect_int(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic directed_pass(string nm);
    wr_cnt = 0;
    done_cnt = 0;
    step(1'b0, 1'b1);
    tbl_r = last_acc;
    for (int i = 0; i < 870; i++) step(1'b0, 1'b0);
    tbl_r = -1;
    expect_int({nm, "_writes"}, wr_cnt, 7);
    expect_int({nm, "_dones"}, done_cnt, 1);
  endtask

  int r1;

  initial begin
    rst = 1'b1;
    fc2_start = 1'b0;

    add(0,   0, K_BUSY, 1);
    add(840, 0, K_BUSY, 1);
    add(841, 0, K_BUSY, 0);
    add(2,   1, K_W6,   0);
    add(2,   1, K_F6,   0);
    add(3,   1, K_W6,   1);
    add(121, 1, K_F6,   119);
    add(122, 1, K_F6,   0);
    add(122, 1, K_W6,   120);
    add(841, 1, K_W6,   839);
    add(4,   1, K_CLR,  0);
    add(5,   1, K_CLR,  1);
    add(125, 1, K_CLR,  1);
    add(725, 1, K_CLR,  1);
    add(127, 1, K_WREN, 0);
    add(128, 1, K_WREN, 1);
    add(128, 1, K_WA,   0);
    add(248, 1, K_WA,   1);
    add(848, 1, K_WREN, 1);
    add(848, 1, K_WA,   6);
    add(849, 1, K_WREN, 0);
    add(848, 1, K_DONE, 0);
    add(849, 1, K_DONE, 1);
    add(850, 1, K_DONE, 0);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    clr_cnt = 0;
    for (int i = 0; i < 1000; i++) step(1'b0, 1'b0);
    expect_int("idle_clr", clr_cnt, 0);

    directed_pass("pass1");

    step(1'b0, 1'b1);
    r1 = last_acc;
    for (int i = 0; i < 845; i++) step(1'b0, 1'b1);
    expect_int("held_start_restart", last_acc - r1, 842);

    while (cyc < last_acc + 299) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    wr_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 1000; i++) step(1'b0, 1'b0);
    expect_int("abort_writes", wr_cnt, 0);
    expect_int("abort_dones", done_cnt, 0);

    directed_pass("pass_after_rst");

    for (int i = 0; i < 6000; i++)
      step(($urandom_range(0, 2999) == 0), ($urandom_range(0, 39) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
